ex_muldiv_seq: RTL

Iterative RV32M multiply/divide sequencer attached to the Execute stage. It accepts one M-extension operation at a time, runs a 32-iteration shift-add multiply or restoring divide, and holds the pipeline stalled while it works. It delivers a single-cycle result strobe with the destination register for the EX/MEM write path. It also handles flushes from branch resolution and the RISC-V divide corner cases.

---
 rtl/ex_muldiv_seq.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq: iterative RV32M multiply/divide sequencer for the Execute stage.
// Runs 32 iterations on operand magnitudes (shift-add or restoring divide), then
// applies a sign fixup. Divide-by-zero and signed overflow bypass the iterations.
module ex_muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic [2:0]      i_func3,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [4:0]      i_rd,
  input  logic            i_flush,
  output logic            o_stall,
  output logic            o_busy,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state, state_nx;
  logic [2:0]          f3_q;
  logic [4:0]          rd_q;
  logic [XLEN-1:0]     opa;   // multiplicand, or dividend shifting into quotient
  logic [XLEN-1:0]     opb;   // multiplier shifting out, or constant divisor
  logic                neg_q;
  logic [2*XLEN-1:0]   acc;   // product, or remainder in the upper half
  logic [CNT_W-1:0]    cnt;

  // Operand decode at the accept cycle
  logic            sgn_a, sgn_b, neg_in, accept, div_zero, div_ovf, special;
  logic [XLEN-1:0] mag_a, mag_b, spec_res;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  // Input-side decode: signedness, magnitudes, result sign, special cases
  always_comb begin
    sgn_a    = i_rs1_data[XLEN-1] & (i_func3[2] ? ~i_func3[0] : (i_func3[1:0] != 2'b11));
    sgn_b    = i_rs2_data[XLEN-1] & (i_func3[2] ? ~i_func3[0] : ~i_func3[1]);
    mag_a    = sgn_a ? -i_rs1_data : i_rs1_data;
    mag_b    = sgn_b ? -i_rs2_data : i_rs2_data;
    // Remainder follows the dividend sign; everything else takes the XOR.
    neg_in   = (i_func3[2] & i_func3[1]) ? sgn_a : (sgn_a ^ sgn_b);
    div_zero = i_func3[2] & (i_rs2_data == '0);
    div_ovf  = i_func3[2] & ~i_func3[0] & (i_rs1_data == MIN_NEG) & (i_rs2_data == '1);
    special  = div_zero | div_ovf;
    accept   = (state == IDLE) & i_start & ~i_flush;
    spec_res = '0;
    if (div_zero)     spec_res = i_func3[1] ? i_rs1_data : '1;
    else if (div_ovf) spec_res = i_func3[1] ? '0 : MIN_NEG;
  end

  // One iteration step and the final sign fixup / result select
  logic [XLEN:0]     mul_sum, div_sh;
  logic [XLEN-1:0]   div_diff, quo, rem, calc_res;
  logic [2*XLEN-1:0] prod;
  logic              div_ge;

  // Datapath combinational: per-iteration step and DONE result
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (opb[0] ? {1'b0, opa} : '0);
    div_sh   = {acc[2*XLEN-1:XLEN], opa[XLEN-1]};
    div_ge   = (div_sh >= {1'b0, opb});
    div_diff = div_sh[XLEN-1:0] - opb;
    prod     = neg_q ? -acc : acc;
    quo      = neg_q ? -opa : opa;
    rem      = neg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (f3_q[2])              calc_res = f3_q[1] ? rem : quo;
    else if (f3_q[1:0] == '0) calc_res = prod[XLEN-1:0];
    else                      calc_res = prod[2*XLEN-1:XLEN];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_nx = state;
    if (i_flush) state_nx = IDLE;
    else begin
      case (state)
        IDLE:    if (i_start) state_nx = special ? DONE : CALC;
        CALC:    if (cnt == '0) state_nx = DONE;
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // FSM outputs; stall is combinational so the accept cycle freezes too
  always_comb begin
    o_busy  = (state != IDLE);
    o_stall = ((state == IDLE) & i_start & ~i_flush) | (state == CALC);
  end

  // Operand latch at accept, then one iteration per CALC cycle until cnt hits 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f3_q  <= '0;
      rd_q  <= '0;
      opa   <= '0;
      opb   <= '0;
      neg_q <= 1'b0;
      acc   <= '0;
      cnt   <= '0;
    end else if (accept) begin
      f3_q  <= i_func3;
      rd_q  <= i_rd;
      opa   <= mag_a;
      opb   <= mag_b;
      neg_q <= neg_in;
      acc   <= '0;
      cnt   <= CNT_W'(XLEN);
    end else if ((state == CALC) && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
      if (f3_q[2]) begin
        acc[2*XLEN-1:XLEN] <= div_ge ? div_diff : div_sh[XLEN-1:0];
        opa                <= {opa[XLEN-2:0], div_ge};
      end else begin
        acc <= {mul_sum, acc[XLEN-1:1]};
        opb <= opb >> 1;
      end
    end
  end

  // Registered result strobe, loaded on the edge that enters DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid  <= 1'b0;
      o_result <= '0;
      o_rd     <= '0;
    end else begin
      o_valid <= (state_nx == DONE);
      if (state_nx == DONE) begin
        o_result <= (state == IDLE) ? spec_res : calc_res;
        o_rd     <= (state == IDLE) ? i_rd : rd_q;
      end
    end
  end

endmodule
